// File: rtl/leaf_stage_pkg.sv
// Shared types and default widths for the leaf valid/ready skid stage.
package leaf_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned CNT_W_DEFAULT  = 16;

endpackage

// File: rtl/leaf_skid_stage.sv
// Registered valid/ready stage with a one-entry skid buffer.
// Optional output-transfer counter enabled by defining LEAF_SKID_STAGE_CNT_EN.
module leaf_skid_stage
    import leaf_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  xfer_count
);

    state_e            state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              in_hs, out_hs;
    logic              load_main, main_from_skid, load_skid;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    load_main = 1'b1;
                end else if (in_hs) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain of the skid entry matters
                if (out_hs) begin
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Payload registers carry no reset; validity lives entirely in state_q.
    always_ff @(posedge clk) begin
        if (load_main) begin
            main_q <= in_data;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

`ifdef LEAF_SKID_STAGE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_hs) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign xfer_count = cnt_q;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_leaf_skid_stage.sv
// Scoreboard bench for leaf_skid_stage: directed vectors plus a random FIFO-model run.
module tb_leaf_skid_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  xfer_count;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                hs_total = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    leaf_skid_stage #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] cnt_model(input int n);
`ifdef LEAF_SKID_STAGE_CNT_EN
        return CNT_W'(n % (1 << CNT_W));
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, log the expected beat if it will be accepted,
    // then return just after the clock edge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        if (iv && in_ready) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle sampling of output handshakes and counter.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hs_total   = 0;
            prev_stall = 1'b0;
        end else begin
            check("xfer_count", DATA_W'(xfer_count), DATA_W'(cnt_model(hs_total)));
            if (prev_stall) begin
                check("stall_valid", DATA_W'(out_valid), DATA_W'(1));
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_data, '0);
                    n_fail += (out_data === '0) ? 1 : 0;
                end else begin
                    check("beat_order", out_data, exp_q.pop_front());
                end
                hs_total++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
        check("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
        check("rst_xfer", DATA_W'(xfer_count), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle
        repeat (5) step(1'b0, '0, 1'b0);
        check("idle_out_valid", DATA_W'(out_valid), DATA_W'(0));
        check("idle_in_ready", DATA_W'(in_ready), DATA_W'(1));
        check("idle_xfer", DATA_W'(xfer_count), '0);

        // Streaming with one-cycle latency
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, DATA_W'(i), 1'b1);
            check("stream_valid", DATA_W'(out_valid), DATA_W'(1));
            check("stream_data", out_data, DATA_W'(i));
            check("stream_in_ready", DATA_W'(in_ready), DATA_W'(1));
        end
        step(1'b0, '0, 1'b1);
        check("stream_drained", DATA_W'(out_valid), DATA_W'(0));
        check("stream_xfer", DATA_W'(xfer_count), DATA_W'(cnt_model(3)));

        // Backpressure into the skid entry
        step(1'b1, 32'hA, 1'b0);
        check("bp_one_data", out_data, 32'hA);
        check("bp_one_ready", DATA_W'(in_ready), DATA_W'(1));
        step(1'b1, 32'hB, 1'b0);
        check("bp_full_ready", DATA_W'(in_ready), DATA_W'(0));
        check("bp_full_data", out_data, 32'hA);
        step(1'b1, 32'hC, 1'b0);
        check("bp_ignore_ready", DATA_W'(in_ready), DATA_W'(0));
        check("bp_ignore_data", out_data, 32'hA);
        step(1'b1, 32'hC, 1'b1);
        check("bp_drain_b", out_data, 32'hB);
        check("bp_ready_back", DATA_W'(in_ready), DATA_W'(1));
        step(1'b1, 32'hC, 1'b1);
        check("bp_accept_c", out_data, 32'hC);
        step(1'b0, '0, 1'b1);
        check("bp_empty", DATA_W'(out_valid), DATA_W'(0));
        check("bp_xfer", DATA_W'(xfer_count), DATA_W'(cnt_model(6)));

        // Random traffic against the FIFO model
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 10 && out_valid; i++) step(1'b0, '0, 1'b1);
        check("rand_drained", DATA_W'(out_valid), DATA_W'(0));
        check("rand_queue_empty", DATA_W'(exp_q.size()), '0);
        check("rand_xfer", DATA_W'(xfer_count), DATA_W'(cnt_model(hs_total)));

        // Asynchronous reset while FULL
        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'h22, 1'b0);
        check("pre_rst_full", DATA_W'(in_ready), DATA_W'(0));
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_out_valid", DATA_W'(out_valid), DATA_W'(0));
        check("arst_in_ready", DATA_W'(in_ready), DATA_W'(1));
        check("arst_xfer", DATA_W'(xfer_count), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("post_rst_idle", DATA_W'(out_valid), DATA_W'(0));
        step(1'b1, 32'h33, 1'b1);
        check("post_rst_data", out_data, 32'h33);

        // Counter wrap at CNT_W=2: 33 already out next edge, then four more
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(32'h40 + i), 1'b1);
        step(1'b0, '0, 1'b1);
        check("wrap_xfer", DATA_W'(xfer_count), DATA_W'(cnt_model(5)));
        step(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
